// File: rtl/sha2_pkg.sv
// ============================================================================
// Module      : sha2_pkg
// Description : Shared SHA-2 types, round count and the message-schedule
//               sigma functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha2_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;
    typedef word_t [15:0] window_t;

    localparam int SCHED_ROUNDS = 64;

    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Element 0 of the window holds W0, which sits in the top bits of the block.
    function automatic window_t block_to_window(input block_t b);
        window_t w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = b[511 - 32*i -: 32];
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msg_sched_expand.sv
// ============================================================================
// Module      : msg_sched_expand
// Description : Combinational next-word computation for the SHA-256 message
//               schedule from the current 16-word window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_sched_expand
    import sha2_pkg::*;
(
    input  window_t window_i,
    output word_t   next_word_o
);

    assign next_word_o = sigma1(window_i[14]) + window_i[9]
                       + sigma0(window_i[1])  + window_i[0];

endmodule

`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
// ============================================================================
// Module      : sha256_msg_schedule
// Description : SHA-256 message schedule; accepts 512-bit blocks and streams
//               W0..W63 with index and last-of-message flag.
//               Build option MSG_SCHED_PIPELINE_EN adds a one-block holding
//               register so consecutive blocks stream without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_schedule
    import sha2_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic [511:0] data_in,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    input  logic         data_in_last,
    output logic [31:0]  data_out,
    output logic [5:0]   data_out_index,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic         data_out_last
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;
    localparam logic [5:0] T_LAST  = 6'(SCHED_ROUNDS - 1);

    logic [0:0] state_q, state_d;
    logic [5:0] t_q, t_d;
    window_t    window_q, window_d;
    logic       last_q, last_d;
    word_t      next_word;

    logic       out_hs;
    logic       in_hs;
    logic       block_end;

`ifdef MSG_SCHED_PIPELINE_EN
    logic       hold_valid_q, hold_valid_d;
    block_t     hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;

    assign data_in_ready = nrst && !hold_valid_q;
`else
    assign data_in_ready = nrst && (state_q == ST_IDLE);
`endif

    assign out_hs    = (state_q == ST_EMIT) && data_out_ready;
    assign in_hs     = data_in_valid && data_in_ready;
    assign block_end = out_hs && (t_q == T_LAST);

    msg_sched_expand u_expand (
        .window_i    (window_q),
        .next_word_o (next_word)
    );

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        window_d = window_q;
        last_d   = last_q;
`ifdef MSG_SCHED_PIPELINE_EN
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    window_d = block_to_window(data_in);
                    last_d   = data_in_last;
                    t_d      = '0;
                    state_d  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    window_d = {next_word, window_q[15:1]};
                    t_d      = t_q + 6'd1;
                end
                if (block_end) begin
`ifdef MSG_SCHED_PIPELINE_EN
                    // A waiting block takes over the window on the final
                    // handshake so its W0 follows W63 directly.
                    if (hold_valid_q) begin
                        window_d     = block_to_window(hold_data_q);
                        last_d       = hold_last_q;
                        t_d          = '0;
                        hold_valid_d = 1'b0;
                    end else if (in_hs) begin
                        window_d = block_to_window(data_in);
                        last_d   = data_in_last;
                        t_d      = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef MSG_SCHED_PIPELINE_EN
                else if (in_hs) begin
                    hold_data_d  = data_in;
                    hold_last_d  = data_in_last;
                    hold_valid_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            window_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            window_q <= window_d;
            last_q   <= last_d;
        end
    end

`ifdef MSG_SCHED_PIPELINE_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
        end
    end
`endif

    assign data_out       = window_q[0];
    assign data_out_index = t_q;
    assign data_out_valid = (state_q == ST_EMIT);
    assign data_out_last  = (state_q == ST_EMIT) && last_q && (t_q == T_LAST);

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
// ============================================================================
// Module      : tb_sha256_msg_schedule
// Description : Self-checking bench for sha256_msg_schedule: directed table
//               vectors plus stall, two-block, back-to-back and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         nrst;
    logic [511:0] data_in;
    logic         data_in_valid;
    logic         data_in_ready;
    logic         data_in_last;
    logic [31:0]  data_out;
    logic [5:0]   data_out_index;
    logic         data_out_valid;
    logic         data_out_ready;
    logic         data_out_last;

    always #5 clk = ~clk;

    sha256_msg_schedule dut (
        .clk            (clk),
        .nrst           (nrst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in_last   (data_in_last),
        .data_out       (data_out),
        .data_out_index (data_out_index),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  idx;
        logic        last;
        int          cyc;
    } obs_t;

    typedef struct {
        int          scen;
        int          idx;
        logic [31:0] d;
        logic        last;
    } vec_t;

    obs_t        cap[$];
    int          cyc_cnt = 0;
    logic [31:0] exp_w [64];
    vec_t        tbl [12];

    // Record each accepted output word mid-cycle, when everything is stable.
    always @(negedge clk) begin
        obs_t o;
        cyc_cnt = cyc_cnt + 1;
        if (nrst && data_out_valid && data_out_ready) begin
            o.d    = data_out;
            o.idx  = data_out_index;
            o.last = data_out_last;
            o.cyc  = cyc_cnt;
            cap.push_back(o);
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, k, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic send_block(input logic [511:0] b, input logic last);
        int k = 0;
        data_in       = b;
        data_in_last  = last;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("send_accept", 0, {31'd0, data_in_ready}, 32'd1);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k = 0;
        while (cap.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("word_count", n, cap.size(), n);
    endtask

    task automatic check_block(input int base, input bit lastflag);
        for (int k = 0; k < 64; k++) begin
            if (base + k < cap.size()) begin
                chk("index", k, 32'(cap[base+k].idx), 32'(k));
                chk("word",  k, cap[base+k].d, exp_w[k]);
                chk("last",  k, {31'd0, cap[base+k].last}, (lastflag && k == 63) ? 32'd1 : 32'd0);
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_word[%0d]: got none, expected one", k);
            end
        end
    endtask

    task automatic apply_table(input int scen);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].scen == scen) begin
                if (tbl[i].idx < cap.size()) begin
                    chk("tbl_word",  i, cap[tbl[i].idx].d, tbl[i].d);
                    chk("tbl_index", i, 32'(cap[tbl[i].idx].idx), 32'(tbl[i].idx));
                    chk("tbl_last",  i, {31'd0, cap[tbl[i].idx].last}, {31'd0, tbl[i].last});
                end else begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tbl_missing[%0d]: got none, expected word %0d", i, tbl[i].idx);
                end
            end
        end
    endtask

    function automatic logic [511:0] pattern_block(input logic [31:0] seed);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = seed * 32'(i + 1) ^ 32'(i * 7);
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc_blk;
        logic [511:0] zero_blk;
        logic [511:0] pat_blk;
        logic [511:0] pat2_blk;
        logic [31:0]  hold_w;
        int           k;
        int           span;

        tbl[0]  = '{0, 0,  32'h61626380, 1'b0};
        tbl[1]  = '{0, 1,  32'h00000000, 1'b0};
        tbl[2]  = '{0, 15, 32'h00000018, 1'b0};
        tbl[3]  = '{0, 16, 32'h61626380, 1'b0};
        tbl[4]  = '{0, 17, 32'h000f0000, 1'b0};
        tbl[5]  = '{0, 18, 32'h7da86405, 1'b0};
        tbl[6]  = '{0, 19, 32'h600003c6, 1'b0};
        tbl[7]  = '{0, 63, 32'h12b1edeb, 1'b1};
        tbl[8]  = '{1, 0,  32'h00000000, 1'b0};
        tbl[9]  = '{1, 31, 32'h00000000, 1'b0};
        tbl[10] = '{1, 62, 32'h00000000, 1'b0};
        tbl[11] = '{1, 63, 32'h00000000, 1'b1};

        abc_blk            = '0;
        abc_blk[511:480]   = 32'h61626380;
        abc_blk[31:0]      = 32'h00000018;
        zero_blk           = '0;
        pat_blk            = pattern_block(32'h9e3779b9);
        pat2_blk           = pattern_block(32'h1234abcd);

        nrst           = 1'b0;
        data_in        = '0;
        data_in_valid  = 1'b1;
        data_in_last   = 1'b0;
        data_out_ready = 1'b0;

        // Reset state, with an input already waiting
        repeat (3) @(negedge clk);
        chk("rst_data",  0, data_out, 32'd0);
        chk("rst_index", 0, 32'(data_out_index), 32'd0);
        chk("rst_valid", 0, {31'd0, data_out_valid}, 32'd0);
        chk("rst_last",  0, {31'd0, data_out_last}, 32'd0);
        chk("rst_ready", 0, {31'd0, data_in_ready}, 32'd0);
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 0, {31'd0, data_in_ready}, 32'd1);
        chk("idle_valid", 0, {31'd0, data_out_valid}, 32'd0);

        // "abc" block
        data_out_ready = 1'b1;
        build_model(abc_blk);
        cap.delete();
        send_block(abc_blk, 1'b1);
        chk("latency_valid", 0, {31'd0, data_out_valid}, 32'd1);
        chk("latency_word",  0, data_out, 32'h61626380);
        wait_words(64);
        check_block(0, 1'b1);
        apply_table(0);
        repeat (3) @(posedge clk); #1;

        // All-zero block
        build_model(zero_blk);
        cap.delete();
        send_block(zero_blk, 1'b1);
        wait_words(64);
        check_block(0, 1'b1);
        apply_table(1);
        repeat (3) @(posedge clk); #1;

        // Consumer stall of five cycles at t=20
        build_model(pat_blk);
        cap.delete();
        send_block(pat_blk, 1'b1);
        k = 0;
        while (!(data_out_valid && data_out_index == 6'd20) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        data_out_ready = 1'b0;
        chk("stall_reached", 0, 32'(data_out_index), 32'd20);
        hold_w = exp_w[20];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_word",  c, data_out, hold_w);
            chk("stall_index", c, 32'(data_out_index), 32'd20);
            chk("stall_valid", c, {31'd0, data_out_valid}, 32'd1);
            chk("stall_last",  c, {31'd0, data_out_last}, 32'd0);
        end
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_index", 0, 32'(data_out_index), 32'd21);
        chk("release_word",  0, data_out, exp_w[21]);
        wait_words(64);
        check_block(0, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Two-block message sent back to back
        cap.delete();
        send_block(pat2_blk, 1'b0);
        send_block(abc_blk, 1'b1);
        wait_words(128);
        build_model(pat2_blk);
        check_block(0, 1'b0);
        build_model(abc_blk);
        check_block(64, 1'b1);
        span = (cap.size() >= 128) ? cap[127].cyc - cap[0].cyc + 1 : 0;
`ifdef MSG_SCHED_PIPELINE_EN
        chk("b2b_cycles", 0, 32'(span), 32'd128);
`else
        chk("b2b_cycles", 0, 32'(span), 32'd129);
`endif
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of a block at t=30
        cap.delete();
        send_block(pat_blk, 1'b1);
        k = 0;
        while (!(data_out_valid && data_out_index == 6'd30) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid_reached", 0, 32'(data_out_index), 32'd30);
        nrst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("mid_rst_data",  c, data_out, 32'd0);
            chk("mid_rst_index", c, 32'(data_out_index), 32'd0);
            chk("mid_rst_valid", c, {31'd0, data_out_valid}, 32'd0);
            chk("mid_rst_last",  c, {31'd0, data_out_last}, 32'd0);
            chk("mid_rst_ready", c, {31'd0, data_in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        build_model(abc_blk);
        cap.delete();
        send_block(abc_blk, 1'b1);
        wait_words(64);
        check_block(0, 1'b1);
        repeat (3) @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
